// File: rtl/perf_counter_pkg.sv
// Shared constants for the performance counter bank: default geometry and
// the index of the free-running cycle counter channel.
package perf_counter_pkg;

    localparam int CNT_WIDTH_DEF = 64;
    localparam int NUM_CH_DEF    = 4;
    localparam int SEL_W_DEF     = 3;
    localparam int CYCLE_CH      = 0;

endpackage

// File: rtl/perf_counter_channel.sv
// One performance counter: event/cycle increment, half-word writes that take
// priority over counting, and a sticky overflow flag set on wrap.
module perf_counter_channel #(
    parameter int CNT_WIDTH = 64,
    parameter bit IS_CYCLE  = 1'b0
) (
    input  logic                 CLK_IP,
    input  logic                 RSTN_IP,
    input  logic                 cnt_event,
    input  logic                 inhibit,
    input  logic                 wr_lo,
    input  logic                 wr_hi,
    input  logic [31:0]          wr_data,
    input  logic                 ovf_clr,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 ovf
);

    logic                 inc;
    logic                 wr_hi_eff;
    logic                 wrap;
    logic [63:0]          hi_ld64;
    logic [CNT_WIDTH-1:0] count_nxt;

    // A write on this cycle swallows the increment, so it can never wrap.
    always_comb begin
        inc       = (IS_CYCLE || cnt_event) && !inhibit;
        wr_hi_eff = wr_hi && (CNT_WIDTH > 32);
        hi_ld64   = {wr_data, count[31:0]};
        count_nxt = count;
        wrap      = 1'b0;
        if (wr_lo) begin
            count_nxt[31:0] = wr_data;
        end else if (wr_hi_eff) begin
            count_nxt = hi_ld64[CNT_WIDTH-1:0];
        end else if (inc) begin
            count_nxt = count + CNT_WIDTH'(1);
            wrap      = &count;
        end
    end

    always_ff @(posedge CLK_IP or negedge RSTN_IP) begin
        if (!RSTN_IP) begin
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            count <= count_nxt;
            ovf   <= wrap | (ovf & ~ovf_clr);
        end
    end

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH performance counters with 32-bit write/read access and a
// shared high-half snapshot so a low-then-high read pair is coherent.
module perf_counter_bank
    import perf_counter_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF,
    parameter int NUM_CH    = NUM_CH_DEF,
    parameter int SEL_W     = SEL_W_DEF
) (
    input  logic              CLK_IP,
    input  logic              RSTN_IP,
    input  logic [NUM_CH-1:0] EVENT_IP,
    input  logic [NUM_CH-1:0] INHIBIT_IP,
    input  logic              WR_EN_IP,
    input  logic [SEL_W-1:0]  WR_SEL_IP,
    input  logic              WR_HI_IP,
    input  logic [31:0]       WR_DATA_IP,
    input  logic              RD_EN_IP,
    input  logic [SEL_W-1:0]  RD_SEL_IP,
    input  logic              RD_HI_IP,
    output logic [31:0]       RD_DATA_OP,
    output logic              RD_VALID_OP,
    input  logic [NUM_CH-1:0] OVF_CLR_IP,
    output logic [NUM_CH-1:0] OVF_OP
);

    logic [CNT_WIDTH-1:0] cnt [NUM_CH];
    logic [NUM_CH-1:0]    wr_hit;
    logic [CNT_WIDTH-1:0] sel_cnt;
    logic [63:0]          sel_ext;
    logic [31:0]          snapshot;

    // Out-of-range write selects match no channel and are dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr_hit[i] = WR_EN_IP && (WR_SEL_IP == SEL_W'(i));

        perf_counter_channel #(
            .CNT_WIDTH (CNT_WIDTH),
            .IS_CYCLE  (i == CYCLE_CH)
        ) u_channel (
            .CLK_IP    (CLK_IP),
            .RSTN_IP   (RSTN_IP),
            .cnt_event (EVENT_IP[i]),
            .inhibit   (INHIBIT_IP[i]),
            .wr_lo     (wr_hit[i] && !WR_HI_IP),
            .wr_hi     (wr_hit[i] && WR_HI_IP),
            .wr_data   (WR_DATA_IP),
            .ovf_clr   (OVF_CLR_IP[i]),
            .count     (cnt[i]),
            .ovf       (OVF_OP[i])
        );
    end

    // Out-of-range read selects fall through to zero.
    always_comb begin
        sel_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (RD_SEL_IP == SEL_W'(i)) begin
                sel_cnt = cnt[i];
            end
        end
        sel_ext = 64'(sel_cnt);
    end

    always_ff @(posedge CLK_IP or negedge RSTN_IP) begin
        if (!RSTN_IP) begin
            RD_DATA_OP  <= '0;
            RD_VALID_OP <= 1'b0;
            snapshot    <= '0;
        end else begin
            RD_VALID_OP <= RD_EN_IP;
            if (RD_EN_IP) begin
                if (RD_HI_IP) begin
                    RD_DATA_OP <= snapshot;
                end else begin
                    RD_DATA_OP <= sel_ext[31:0];
                    snapshot   <= sel_ext[63:32];
                end
            end
        end
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: table of one-cycle vectors for
// channels 1..3 plus hand sequences for the cycle counter and async reset.
module tb_perf_counter_bank;

    logic        CLK_IP;
    logic        RSTN_IP;
    logic [3:0]  EVENT_IP;
    logic [3:0]  INHIBIT_IP;
    logic        WR_EN_IP;
    logic [2:0]  WR_SEL_IP;
    logic        WR_HI_IP;
    logic [31:0] WR_DATA_IP;
    logic        RD_EN_IP;
    logic [2:0]  RD_SEL_IP;
    logic        RD_HI_IP;
    logic [31:0] RD_DATA_OP;
    logic        RD_VALID_OP;
    logic [3:0]  OVF_CLR_IP;
    logic [3:0]  OVF_OP;

    int n_checks = 0;
    int n_pass   = 0;
    longint unsigned ch0_model;

    perf_counter_bank dut (
        .CLK_IP      (CLK_IP),
        .RSTN_IP     (RSTN_IP),
        .EVENT_IP    (EVENT_IP),
        .INHIBIT_IP  (INHIBIT_IP),
        .WR_EN_IP    (WR_EN_IP),
        .WR_SEL_IP   (WR_SEL_IP),
        .WR_HI_IP    (WR_HI_IP),
        .WR_DATA_IP  (WR_DATA_IP),
        .RD_EN_IP    (RD_EN_IP),
        .RD_SEL_IP   (RD_SEL_IP),
        .RD_HI_IP    (RD_HI_IP),
        .RD_DATA_OP  (RD_DATA_OP),
        .RD_VALID_OP (RD_VALID_OP),
        .OVF_CLR_IP  (OVF_CLR_IP),
        .OVF_OP      (OVF_OP)
    );

    initial CLK_IP = 1'b0;
    always #5 CLK_IP = ~CLK_IP;

    // Reference value of the cycle counter, advanced on every unhalted edge.
    always @(posedge CLK_IP or negedge RSTN_IP) begin
        if (!RSTN_IP) ch0_model <= 0;
        else if (!INHIBIT_IP[0]) ch0_model <= ch0_model + 1;
    end

    typedef struct {
        logic        wr_en;
        logic [2:0]  wr_sel;
        logic        wr_hi;
        logic [31:0] wr_data;
        logic [3:0]  ev;
        logic [3:0]  inh;
        logic [3:0]  clr;
        logic        rd_en;
        logic [2:0]  rd_sel;
        logic        rd_hi;
        logic [31:0] exp_data;
        logic        exp_valid;
        logic [3:0]  exp_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic wr_en, logic [2:0] wr_sel, logic wr_hi, logic [31:0] wr_data,
                                logic [3:0] ev, logic [3:0] inh, logic [3:0] clr,
                                logic rd_en, logic [2:0] rd_sel, logic rd_hi,
                                logic [31:0] exp_data, logic exp_valid, logic [3:0] exp_ovf);
        vec_t v;
        v.wr_en = wr_en;   v.wr_sel = wr_sel; v.wr_hi = wr_hi; v.wr_data = wr_data;
        v.ev = ev;         v.inh = inh;       v.clr = clr;
        v.rd_en = rd_en;   v.rd_sel = rd_sel; v.rd_hi = rd_hi;
        v.exp_data = exp_data; v.exp_valid = exp_valid; v.exp_ovf = exp_ovf;
        return v;
    endfunction

    task automatic tick();
        @(posedge CLK_IP);
        #1;
    endtask

    task automatic clearInputs();
        EVENT_IP = '0; INHIBIT_IP = '0; WR_EN_IP = 0; WR_SEL_IP = '0; WR_HI_IP = 0;
        WR_DATA_IP = '0; RD_EN_IP = 0; RD_SEL_IP = '0; RD_HI_IP = 0; OVF_CLR_IP = '0;
    endtask

    task automatic applyStimulus(input vec_t v);
        WR_EN_IP = v.wr_en; WR_SEL_IP = v.wr_sel; WR_HI_IP = v.wr_hi; WR_DATA_IP = v.wr_data;
        EVENT_IP = v.ev; INHIBIT_IP = v.inh; OVF_CLR_IP = v.clr;
        RD_EN_IP = v.rd_en; RD_SEL_IP = v.rd_sel; RD_HI_IP = v.rd_hi;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    endtask

    task automatic readCheck(input string name, input logic [2:0] sel, input logic hi,
                             input logic [31:0] exp);
        RD_EN_IP = 1; RD_SEL_IP = sel; RD_HI_IP = hi;
        tick();
        RD_EN_IP = 0;
        checkOutput({name, " data"}, RD_DATA_OP, exp);
        checkOutput({name, " valid"}, 32'(RD_VALID_OP), 32'd1);
    endtask

    initial begin
        logic [31:0] exp_ch0;

        clearInputs();
        RSTN_IP = 1;
        #2 RSTN_IP = 0;
        #1;
        checkOutput("reset data", RD_DATA_OP, 32'd0);
        checkOutput("reset valid", 32'(RD_VALID_OP), 32'd0);
        checkOutput("reset ovf", 32'(OVF_OP), 32'd0);

        repeat (2) tick();
        @(negedge CLK_IP);
        RSTN_IP = 1;
        repeat (10) tick();
        readCheck("ch0 after 10 cycles", 3'd0, 1'b0, 32'd10);

        //          wr sel hi data          ev      inh     clr     rd sel hi  exp_data      v  ovf
        vecs.push_back(mk(0, 1, 0, 32'h0,        4'b0000, 4'b0000, 4'b0000, 1, 1, 0, 32'h0,        1, 4'b0000));
        vecs.push_back(mk(0, 2, 0, 32'h0,        4'b0000, 4'b0000, 4'b0000, 1, 2, 0, 32'h0,        1, 4'b0000));
        vecs.push_back(mk(0, 3, 0, 32'h0,        4'b0000, 4'b0000, 4'b0000, 1, 3, 0, 32'h0,        1, 4'b0000));
        vecs.push_back(mk(0, 0, 0, 32'h0,        4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 32'h0,        0, 4'b0000));
        vecs.push_back(mk(1, 1, 0, 32'hFFFFFFFF, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 32'h0,        0, 4'b0000));
        vecs.push_back(mk(1, 1, 1, 32'hFFFFFFFF, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 32'h0,        0, 4'b0000));
        vecs.push_back(mk(0, 0, 0, 32'h0,        4'b0010, 4'b0000, 4'b0000, 0, 0, 0, 32'h0,        0, 4'b0010));
        vecs.push_back(mk(0, 0, 0, 32'h0,        4'b0000, 4'b0000, 4'b0000, 1, 1, 0, 32'h0,        1, 4'b0010));
        vecs.push_back(mk(0, 0, 0, 32'h0,        4'b0000, 4'b0000, 4'b0000, 1, 1, 1, 32'h0,        1, 4'b0010));
        vecs.push_back(mk(0, 0, 0, 32'h0,        4'b0000, 4'b0000, 4'b0010, 0, 0, 0, 32'h0,        0, 4'b0000));
        vecs.push_back(mk(1, 2, 0, 32'hFFFFFFFF, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 32'h0,        0, 4'b0000));
        vecs.push_back(mk(0, 0, 0, 32'h0,        4'b0000, 4'b0000, 4'b0000, 1, 2, 0, 32'hFFFFFFFF, 1, 4'b0000));
        vecs.push_back(mk(0, 0, 0, 32'h0,        4'b0100, 4'b0000, 4'b0000, 0, 0, 0, 32'hFFFFFFFF, 0, 4'b0000));
        vecs.push_back(mk(0, 0, 0, 32'h0,        4'b0000, 4'b0000, 4'b0000, 1, 2, 1, 32'h0,        1, 4'b0000));
        vecs.push_back(mk(0, 0, 0, 32'h0,        4'b0000, 4'b0000, 4'b0000, 1, 2, 0, 32'h0,        1, 4'b0000));
        vecs.push_back(mk(0, 0, 0, 32'h0,        4'b0000, 4'b0000, 4'b0000, 1, 2, 1, 32'h1,        1, 4'b0000));
        vecs.push_back(mk(1, 3, 0, 32'h5,        4'b1000, 4'b0000, 4'b0000, 0, 0, 0, 32'h1,        0, 4'b0000));
        vecs.push_back(mk(0, 0, 0, 32'h0,        4'b0000, 4'b0000, 4'b0000, 1, 3, 0, 32'h5,        1, 4'b0000));
        vecs.push_back(mk(1, 3, 0, 32'hABCD,     4'b0000, 4'b0000, 4'b0000, 1, 3, 0, 32'h5,        1, 4'b0000));
        vecs.push_back(mk(0, 0, 0, 32'h0,        4'b0000, 4'b0000, 4'b0000, 1, 3, 0, 32'hABCD,     1, 4'b0000));
        vecs.push_back(mk(0, 0, 0, 32'h0,        4'b1000, 4'b1000, 4'b0000, 0, 0, 0, 32'hABCD,     0, 4'b0000));
        vecs.push_back(mk(0, 0, 0, 32'h0,        4'b0000, 4'b0000, 4'b0000, 1, 3, 0, 32'hABCD,     1, 4'b0000));
        vecs.push_back(mk(0, 0, 0, 32'h0,        4'b1000, 4'b0000, 4'b0000, 0, 0, 0, 32'hABCD,     0, 4'b0000));
        vecs.push_back(mk(0, 0, 0, 32'h0,        4'b1000, 4'b0000, 4'b0000, 1, 3, 0, 32'hABCE,     1, 4'b0000));
        vecs.push_back(mk(0, 0, 0, 32'h0,        4'b0000, 4'b0000, 4'b0000, 1, 3, 0, 32'hABCF,     1, 4'b0000));
        vecs.push_back(mk(0, 0, 0, 32'h0,        4'b0000, 4'b0000, 4'b0000, 1, 2, 0, 32'h0,        1, 4'b0000));
        vecs.push_back(mk(0, 0, 0, 32'h0,        4'b0000, 4'b0000, 4'b0000, 1, 0, 1, 32'h1,        1, 4'b0000));
        vecs.push_back(mk(0, 0, 0, 32'h0,        4'b0000, 4'b0000, 4'b0000, 1, 7, 0, 32'h0,        1, 4'b0000));
        vecs.push_back(mk(0, 0, 0, 32'h0,        4'b0000, 4'b0000, 4'b0000, 1, 2, 1, 32'h0,        1, 4'b0000));
        vecs.push_back(mk(1, 1, 0, 32'hFFFFFFFF, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 32'h0,        0, 4'b0000));
        vecs.push_back(mk(1, 1, 1, 32'hFFFFFFFF, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 32'h0,        0, 4'b0000));
        vecs.push_back(mk(0, 0, 0, 32'h0,        4'b0010, 4'b0000, 4'b0010, 0, 0, 0, 32'h0,        0, 4'b0010));
        vecs.push_back(mk(0, 0, 0, 32'h0,        4'b0000, 4'b0000, 4'b0010, 0, 0, 0, 32'h0,        0, 4'b0000));
        vecs.push_back(mk(1, 1, 1, 32'hFFFFFFFF, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 32'h0,        0, 4'b0000));
        vecs.push_back(mk(1, 1, 0, 32'hFFFFFFFF, 4'b0010, 4'b0000, 4'b0000, 0, 0, 0, 32'h0,        0, 4'b0000));
        vecs.push_back(mk(0, 0, 0, 32'h0,        4'b0000, 4'b0000, 4'b0000, 1, 1, 0, 32'hFFFFFFFF, 1, 4'b0000));
        vecs.push_back(mk(0, 0, 0, 32'h0,        4'b0000, 4'b0000, 4'b0000, 1, 1, 1, 32'hFFFFFFFF, 1, 4'b0000));
        vecs.push_back(mk(1, 5, 0, 32'h1234,     4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 32'hFFFFFFFF, 0, 4'b0000));
        vecs.push_back(mk(0, 0, 0, 32'h0,        4'b0000, 4'b0000, 4'b0000, 1, 1, 0, 32'hFFFFFFFF, 1, 4'b0000));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            tick();
            checkOutput($sformatf("vec%0d data", i), RD_DATA_OP, vecs[i].exp_data);
            checkOutput($sformatf("vec%0d valid", i), 32'(RD_VALID_OP), 32'(vecs[i].exp_valid));
            checkOutput($sformatf("vec%0d ovf", i), 32'(OVF_OP), 32'(vecs[i].exp_ovf));
        end
        clearInputs();

        // Cycle counter tracks the reference, then freezes while inhibited.
        exp_ch0 = ch0_model[31:0];
        readCheck("ch0 running", 3'd0, 1'b0, exp_ch0);
        INHIBIT_IP[0] = 1;
        exp_ch0 = ch0_model[31:0];
        repeat (20) tick();
        readCheck("ch0 inhibited", 3'd0, 1'b0, exp_ch0);
        INHIBIT_IP[0] = 0;

        // Async reset with live state: ch1 is all-ones, so one event sets ovf[1].
        EVENT_IP = 4'b0010;
        tick();
        EVENT_IP = '0;
        checkOutput("pre-reset ovf", 32'(OVF_OP), 32'h2);
        readCheck("pre-reset read", 3'd3, 1'b0, 32'hABCF);
        RD_EN_IP = 1;
        #2 RSTN_IP = 0;
        #1;
        checkOutput("async reset data", RD_DATA_OP, 32'd0);
        checkOutput("async reset valid", 32'(RD_VALID_OP), 32'd0);
        checkOutput("async reset ovf", 32'(OVF_OP), 32'd0);
        tick();
        RD_EN_IP = 0;
        @(negedge CLK_IP);
        RSTN_IP = 1;
        tick();
        checkOutput("post-reset valid", 32'(RD_VALID_OP), 32'd0);
        repeat (2) tick();
        readCheck("ch0 3 cycles after reset", 3'd0, 1'b0, 32'd3);
        readCheck("ch1 after reset", 3'd1, 1'b0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
